// File: rtl/rs_pkg.sv
// Shared definitions for the return-address stack: overflow-mode constants and
// the per-cycle operation decoded from the push/pop request pair.
package rs_pkg;

   localparam int unsigned RS_REJECT = 0;
   localparam int unsigned RS_WRAP   = 1;

   typedef enum logic [1:0] {
      NOP     = 2'b00,
      PUSH    = 2'b01,
      POP     = 2'b10,
      REPLACE = 2'b11
   } rs_op_t;

   function automatic rs_op_t decode_op(input logic push, input logic pop);
      return rs_op_t'({pop, push});
   endfunction

endpackage

// File: rtl/rs_storage.sv
// DEPTH x WIDTH return-address array: one synchronous write port and one
// asynchronous read port, addressed by the owning stack's pointer logic.
module rs_storage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clock,
   input  logic             we,
   input  logic [PW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   // No reset: occupancy is tracked entirely by the owner's pointer and count.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Hardware return-address stack: circular buffer with registered top entry,
// occupancy status, sticky error flags, overwrite-oldest mode and replace.
module return_stack
   import rs_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned OVF_MODE = RS_REJECT
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       clear_err,
   output logic [WIDTH-1:0]           top,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic WRAP = (OVF_MODE == RS_WRAP);

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    ptr_next;
   logic [PW-1:0]    ptr_prev;
   logic [PW-1:0]    ptr_prev2;
   logic [PW-1:0]    waddr;
   logic             we;
   logic [WIDTH-1:0] below_top;
   rs_op_t           op;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // Modulo-DEPTH neighbours of wr_ptr; DEPTH need not be a power of two.
   assign ptr_next  = (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
   assign ptr_prev  = (wr_ptr == '0) ? LAST : wr_ptr - PW'(1);
   assign ptr_prev2 = (wr_ptr == '0)      ? PW'(DEPTH - 2) :
                      (wr_ptr == PW'(1))  ? LAST :
                                            wr_ptr - PW'(2);

   // push+pop on an empty stack has nothing to replace, so it is a plain push.
   always_comb begin
      op = decode_op(push, pop);
      if (op == REPLACE && empty) begin
         op = PUSH;
      end
   end

   always_comb begin
      we    = 1'b0;
      waddr = wr_ptr;
      case (op)
         PUSH:    we = !full || WRAP;
         REPLACE: begin
            we    = 1'b1;
            waddr = ptr_prev;
         end
         default: ;
      endcase
   end

   rs_storage #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_storage (
      .clock (clock),
      .we    (we),
      .waddr (waddr),
      .wdata (push_data),
      .raddr (ptr_prev2),
      .rdata (below_top)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         count     <= '0;
         top       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // Error sets below are written after the clear so they take priority.
         if (clear_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end
         case (op)
            PUSH: begin
               if (!full) begin
                  wr_ptr <= ptr_next;
                  count  <= count + CW'(1);
                  top    <= push_data;
               end else begin
                  overflow <= 1'b1;
                  if (WRAP) begin
                     wr_ptr <= ptr_next;
                     top    <= push_data;
                  end
               end
            end
            POP: begin
               if (!empty) begin
                  wr_ptr <= ptr_prev;
                  count  <= count - CW'(1);
                  top    <= (count >= CW'(2)) ? below_top : '0;
               end else begin
                  underflow <= 1'b1;
               end
            end
            REPLACE: top <= push_data;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack (WIDTH=8, DEPTH=4): one reject-mode and one
// wrap-mode instance driven by the same stimulus, checked against hand values.
module tb_return_stack;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       push;
   logic       pop;
   logic [7:0] push_data;
   logic       clear_err;

   logic [7:0] r_top, w_top;
   logic [2:0] r_count, w_count;
   logic       r_empty, r_full, r_ovf, r_udf;
   logic       w_empty, w_full, w_ovf, w_udf;

   int unsigned total = 0;
   int unsigned fails = 0;

   always #5 clock = ~clock;

   return_stack #(.WIDTH(8), .DEPTH(4), .OVF_MODE(0)) u_rej (
      .clock(clock), .reset_n(reset_n), .push(push), .pop(pop),
      .push_data(push_data), .clear_err(clear_err),
      .top(r_top), .count(r_count), .empty(r_empty), .full(r_full),
      .overflow(r_ovf), .underflow(r_udf)
   );

   return_stack #(.WIDTH(8), .DEPTH(4), .OVF_MODE(1)) u_wrap (
      .clock(clock), .reset_n(reset_n), .push(push), .pop(pop),
      .push_data(push_data), .clear_err(clear_err),
      .top(w_top), .count(w_count), .empty(w_empty), .full(w_full),
      .overflow(w_ovf), .underflow(w_udf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, then settle past the rising edge.
   task automatic step(input logic rst_n, input logic ps, input logic pp,
                       input logic [7:0] d, input logic clr);
      @(negedge clock);
      reset_n   = rst_n;
      push      = ps;
      pop       = pp;
      push_data = d;
      clear_err = clr;
      @(posedge clock);
      #1;
   endtask

   task automatic chk_both(input string tag, input logic [7:0] top_e, input logic [2:0] cnt_e,
                           input logic ovf_e, input logic udf_e);
      chk({tag, " rej.top"}, r_top, top_e);
      chk({tag, " rej.count"}, r_count, cnt_e);
      chk({tag, " rej.flags"}, {r_ovf, r_udf}, {ovf_e, udf_e});
      chk({tag, " wrap.top"}, w_top, top_e);
      chk({tag, " wrap.count"}, w_count, cnt_e);
      chk({tag, " wrap.flags"}, {w_ovf, w_udf}, {ovf_e, udf_e});
   endtask

   initial begin
      reset_n = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0; clear_err = 1'b0;
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk_both("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      chk("reset empty/full", {r_empty, r_full, w_empty, w_full}, 4'b1010);

      step(1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
      chk_both("push11", 8'h11, 3'd1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h22, 1'b0);
      chk_both("push22", 8'h22, 3'd2, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
      chk_both("push33", 8'h33, 3'd3, 1'b0, 1'b0);
      chk("push33 empty", {r_empty, w_empty}, 2'b00);
      step(1'b1, 1'b1, 1'b0, 8'h44, 1'b0);
      chk_both("push44", 8'h44, 3'd4, 1'b0, 1'b0);
      chk("push44 full", {r_full, w_full}, 2'b11);

      // Push while full: reject keeps 0x44, wrap overwrites oldest (0x11).
      step(1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
      chk("ovf rej.top", r_top, 8'h44);
      chk("ovf wrap.top", w_top, 8'h55);
      chk("ovf counts", {r_count, w_count}, {3'd4, 3'd4});
      chk("ovf flags", {r_ovf, r_udf, w_ovf, w_udf}, 4'b1010);

      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      chk("pop1 tops", {r_top, w_top}, {8'h33, 8'h44});
      chk("pop1 counts", {r_count, w_count}, {3'd3, 3'd3});
      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      chk("pop2 tops", {r_top, w_top}, {8'h22, 8'h33});
      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      chk("pop3 tops", {r_top, w_top}, {8'h11, 8'h22});
      chk("pop3 counts", {r_count, w_count}, {3'd1, 3'd1});
      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      chk_both("pop4", 8'h00, 3'd0, 1'b1, 1'b0);
      chk("pop4 empty", {r_empty, r_full, w_empty, w_full}, 4'b1010);

      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      chk_both("pop empty", 8'h00, 3'd0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk_both("clear_err", 8'h00, 3'd0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
      chk_both("clear+pop empty", 8'h00, 3'd0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk_both("clear again", 8'h00, 3'd0, 1'b0, 1'b0);

      step(1'b1, 1'b1, 1'b0, 8'hA0, 1'b0);
      chk_both("pushA0", 8'hA0, 3'd1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 8'hB0, 1'b0);
      chk_both("replaceB0", 8'hB0, 3'd1, 1'b0, 1'b0);
      // Replaced value must actually be in storage below the next push.
      step(1'b1, 1'b1, 1'b0, 8'hB1, 1'b0);
      chk_both("pushB1", 8'hB1, 3'd2, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      chk_both("pop to B0", 8'hB0, 3'd1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      chk_both("pop to empty", 8'h00, 3'd0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 8'hC0, 1'b0);
      chk_both("push+pop empty", 8'hC0, 3'd1, 1'b0, 1'b0);

      step(1'b1, 1'b1, 1'b0, 8'hC1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'hC2, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0);
      chk_both("fill C3", 8'hC3, 3'd4, 1'b0, 1'b0);
      // Replace while full: no overflow, count unchanged.
      step(1'b1, 1'b1, 1'b1, 8'hD0, 1'b0);
      chk_both("replace full", 8'hD0, 3'd4, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      chk_both("pop after replace", 8'hC2, 3'd3, 1'b0, 1'b0);

      step(1'b0, 1'b1, 1'b0, 8'hEE, 1'b0);
      chk_both("reset with push", 8'h00, 3'd0, 1'b0, 1'b0);
      chk("reset empty", {r_empty, w_empty}, 2'b11);
      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      chk_both("pop after reset", 8'h00, 3'd0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
